// File: rtl/uart_lock_status_tx.sv
// uart_lock_status_tx: announces the lock state over an 8N1 UART TX line.
// A message ("OPEN\r\n" / "CLOSED\r\n") is sent whenever lock_open differs
// from the last announced state, or when a status request is seen.
module uart_lock_status_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic lock_open,
    input  logic status_req,
    output logic tx_pin,
    output logic tx_busy
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [BW-1:0] baud_cnt, baud_n;
    logic [2:0]    bit_idx, bit_n;
    logic [2:0]    byte_idx, byte_n;
    logic          sel, sel_n;
    logic          reported, rep_n;
    logic          req_pending, pend_n;
    logic          tx_n, busy_n;
    logic [7:0]    cur_byte;
    logic          baud_done, last_byte, trigger;

    assign baud_done = (baud_cnt == BW'(CLKS_PER_BIT - 1));
    assign last_byte = sel ? (byte_idx == 3'd5) : (byte_idx == 3'd7);
    assign trigger   = (lock_open != reported) || req_pending || status_req;

    // Message ROM: byte of the selected message at the current byte index
    always_comb begin
        cur_byte = 8'h0A;
        case ({sel, byte_idx})
            4'b1_000: cur_byte = 8'h4F;  // O
            4'b1_001: cur_byte = 8'h50;  // P
            4'b1_010: cur_byte = 8'h45;  // E
            4'b1_011: cur_byte = 8'h4E;  // N
            4'b1_100: cur_byte = 8'h0D;
            4'b1_101: cur_byte = 8'h0A;
            4'b0_000: cur_byte = 8'h43;  // C
            4'b0_001: cur_byte = 8'h4C;  // L
            4'b0_010: cur_byte = 8'h4F;  // O
            4'b0_011: cur_byte = 8'h53;  // S
            4'b0_100: cur_byte = 8'h45;  // E
            4'b0_101: cur_byte = 8'h44;  // D
            4'b0_110: cur_byte = 8'h0D;
            4'b0_111: cur_byte = 8'h0A;
            default:  cur_byte = 8'h0A;
        endcase
    end

    // Next-state logic; tx_n/busy_n are the registered line values for the
    // coming cycle, so the pin always comes straight from a flop.
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_idx;
        byte_n  = byte_idx;
        sel_n   = sel;
        rep_n   = reported;
        pend_n  = req_pending | status_req;
        tx_n    = tx_pin;
        busy_n  = tx_busy;
        case (state)
            IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                baud_n = '0;
                if (trigger) begin
                    state_n = START;
                    sel_n   = lock_open;
                    rep_n   = lock_open;
                    // A request that is itself the trigger is consumed here;
                    // one riding along with another trigger is kept for later.
                    pend_n  = status_req && ((lock_open != reported) || req_pending);
                    byte_n  = 3'd0;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_n  = '0;
                    state_n = DATA;
                    bit_n   = 3'd0;
                    tx_n    = cur_byte[0];
                end else begin
                    baud_n = baud_cnt + BW'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                        tx_n  = cur_byte[bit_idx + 3'd1];
                    end
                end else begin
                    baud_n = baud_cnt + BW'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_n = '0;
                    if (last_byte) begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        // Back-to-back bytes: no idle gap inside a message
                        byte_n  = byte_idx + 3'd1;
                        state_n = START;
                        tx_n    = 1'b0;
                    end
                end else begin
                    baud_n = baud_cnt + BW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= 3'd0;
            byte_idx    <= 3'd0;
            sel         <= 1'b0;
            reported    <= 1'b0;
            req_pending <= 1'b0;
            tx_pin      <= 1'b1;
            tx_busy     <= 1'b0;
        end else begin
            state       <= state_n;
            baud_cnt    <= baud_n;
            bit_idx     <= bit_n;
            byte_idx    <= byte_n;
            sel         <= sel_n;
            reported    <= rep_n;
            req_pending <= pend_n;
            tx_pin      <= tx_n;
            tx_busy     <= busy_n;
        end
    end

endmodule

// File: doc/uart_lock_status_tx.md
# uart_lock_status_tx

Reports the electronic lock's state back to the host over the UART transmit line. It watches the `lock_open` level produced by the lock controller and sends an ASCII message whenever that level changes. It also sends one on an explicit status request. It sits beside the UART lock command receiver on the same clock and drives the board's TX pin. It contains its own 8N1 bit serializer and a message sequencer.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (115200 baud at 50 MHz). Must be ≥ 2.

Ports:
- `clk`  input  1  system clock; all logic rises on this edge.
- `rst`  input  1  reset, asynchronous, active-low (0 = reset).
- `lock_open`  input  1  lock state from the lock controller, synchronous to `clk`. 1 = open.
- `status_req`  input  1  single-cycle pulse requesting a report of the current state.
- `tx_pin`  output  1  UART serial out, 8N1, LSB first, idle high.
- `tx_busy`  output  1  high while a message is being transmitted.

## Operation
- Messages, in ASCII:
  - Open: "OPEN\r\n" = 4F 50 45 4E 0D 0A (6 bytes).
  - Closed: "CLOSED\r\n" = 43 4C 4F 53 45 44 0D 0A (8 bytes).
- Internal state:
  - `reported`: the last state announced. Resets to 0 (closed).
  - `req_pending`: a latched status request.
  - Byte index counter: 0–7.
  - Bit index counter: 0–7.
  - Baud counter: 0 to `CLKS_PER_BIT`−1.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - Trigger condition: `lock_open != reported`, or `req_pending`, or `status_req`.
  - On trigger: snapshot `lock_open` as the message selector, set `reported <= lock_open`, clear `req_pending`, set byte index to 0, then go to START.
- START: drive 0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
- DATA:
  - Drive the current byte's bit[bit index] for `CLKS_PER_BIT` cycles.
  - After bit 7, go to STOP.
- STOP:
  - Drive 1 for `CLKS_PER_BIT` cycles.
  - If this was the last byte of the message, return to IDLE.
  - Otherwise increment the byte index and go directly to START, with no idle gap between bytes.
- `status_req` arriving outside IDLE, or in the same cycle a trigger is taken, sets `req_pending`. Multiple requests collapse into one.
- `lock_open` changes during a message do not alter the message in flight.
  - On return to IDLE, the comparison is re-evaluated.
  - Open → closed → open within one "OPEN" message produces no further message.
  - A net change produces exactly one follow-up message.
- No message is sent on exit from reset while `lock_open` = 0.
  - If `lock_open` = 1 when reset is released, "OPEN\r\n" is sent.
- Reset asserted mid-message:
  - `tx_pin` goes to 1 immediately and `tx_busy` to 0.
  - The FSM returns to IDLE and all counters, `reported` and `req_pending` clear.
  - The partial frame is abandoned and not resumed.

## Timing
- Reset values: `tx_pin` = 1, `tx_busy` = 0, FSM = IDLE.
- Latency: when the trigger condition is true at clock edge N, `tx_pin` falls and `tx_busy` rises on edge N+1.
- Each bit lasts exactly `CLKS_PER_BIT` cycles. One byte lasts 10×`CLKS_PER_BIT` cycles (4340 at default).
- Message length:
  - "OPEN\r\n": 60×`CLKS_PER_BIT` = 26040 cycles.
  - "CLOSED\r\n": 80×`CLKS_PER_BIT` = 34720 cycles.
- `tx_busy` falls on the same edge that ends the last stop bit.
- The FSM spends at least one cycle in IDLE between messages, so successive messages are separated by ≥ 1 cycle of idle-high beyond the stop bit.
- `tx_pin` is driven from a register; it never glitches.

## Test plan
- Reset with `lock_open` = 0 and hold 50000 cycles → `tx_pin` stays 1 and `tx_busy` stays 0 throughout.
- Raise `lock_open` at cycle 100 → start bit at cycle 101. The bench UART model decodes 4F 50 45 4E 0D 0A. `tx_busy` is high for exactly 26040 cycles.
- With `lock_open` = 1 and idle, drop `lock_open` → 43 4C 4F 53 45 44 0D 0A decoded, 34720 busy cycles, every bit width exactly 434 cycles.
- Raise `lock_open`, then 1000 cycles later drop it, then 2000 cycles later raise it again → exactly one "OPEN\r\n" is sent and no follow-up. Separately, a single drop after 1000 cycles → "OPEN\r\n" followed by "CLOSED\r\n", with ≥ 1 idle cycle between them.
- Pulse `status_req` three times during an "OPEN" message → exactly one extra "OPEN\r\n" follows. A `status_req` while idle with `lock_open` = 0 → "CLOSED\r\n".
- Assert `rst` = 0 mid-way through byte 3 of "CLOSED\r\n" → `tx_pin` = 1 and `tx_busy` = 0 within the same cycle, no further output. Release with `lock_open` = 0 → line stays idle.
